// File: rtl/adf4351_seq.sv
// ADF4351 programming sequencer: forwards DSP register writes to the SPI config
// stage, launches program bursts, qualifies PLL lock and supervises loss of lock.
module adf4351_seq #(
    parameter int POWERUP_DLY = 1000,
    parameter int SPI_TO      = 4096,
    parameter int SETTLE      = 2000,
    parameter int LOL_FILT    = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic        spi_clk,
    input  logic        sys_rest_n,
    input  logic        dsp_wr_valid,
    input  logic [7:0]  dsp_wr_addr,
    input  logic [31:0] dsp_wr_data,
    output logic [31:0] adf_in_data,
    output logic [7:0]  adf_cfg_rddr,
    output logic        adf_data_valid,
    output logic        adf_wr_en,
    output logic        adf4351_spi_start,
    input  logic        spi_all_end,
    input  logic        adf_ld,
    output logic        seq_busy,
    output logic        seq_locked,
    output logic        seq_fail,
    output logic        spi_timeout,
    output logic        lol_flag,
    output logic        wr_drop,
    output logic [2:0]  retry_cnt,
    output logic [7:0]  lol_cnt
);

    // All timing parameters share one 16-bit timer, so each must fit in 16 bits.
    localparam logic [15:0] PU_LAST     = 16'(POWERUP_DLY - 1);
    localparam logic [15:0] TO_LAST     = 16'(SPI_TO - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] LOL_LAST    = 16'(LOL_FILT - 1);
    localparam logic [2:0]  RETRY_LIM   = 3'(MAX_RETRY);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PU_WAIT,
        ST_START,
        ST_WAIT_END,
        ST_SETTLE,
        ST_CHECK,
        ST_RETRY,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic [2:0]  retry_nxt;
    logic        pend_commit, pend_nxt;
    logic        tmo_set, lol_evt;
    logic        ld_p0, ld_p1, ld_s;
    logic        end_p0, end_rise;
    logic        busy, wr_reg, wr_ctl, wr_fwd, commit, clr;
    logic [7:0]  lol_cnt_nxt;

    function automatic logic is_rest(input state_t s);
        return (s == ST_IDLE) || (s == ST_LOCKED) || (s == ST_FAIL);
    endfunction

    // Stage p0/p1: lock-detect synchronizer and end-of-burst edge register
    always_ff @(posedge spi_clk or negedge sys_rest_n) begin
        if (!sys_rest_n) begin
            ld_p0  <= 1'b0;
            ld_p1  <= 1'b0;
            end_p0 <= 1'b0;
        end else begin
            ld_p0  <= adf_ld;
            ld_p1  <= ld_p0;
            end_p0 <= spi_all_end;
        end
    end

    assign ld_s     = ld_p1;
    assign end_rise = spi_all_end & ~end_p0;

    assign busy   = !is_rest(state);
    assign wr_reg = dsp_wr_valid && (dsp_wr_addr >= 8'hA0) && (dsp_wr_addr <= 8'hA5);
    assign wr_ctl = dsp_wr_valid && (dsp_wr_addr == 8'hA6);
    assign wr_fwd = wr_reg && !busy;
    assign commit = wr_ctl && dsp_wr_data[0];
    assign clr    = wr_ctl && dsp_wr_data[1];

    assign adf_wr_en = 1'b0;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        retry_nxt = retry_cnt;
        pend_nxt  = pend_commit;
        tmo_set   = 1'b0;
        lol_evt   = 1'b0;
        if (commit && busy) begin
            pend_nxt = 1'b1;
        end
        case (state)
            ST_PU_WAIT: begin
                if (timer == PU_LAST) begin
                    state_nxt = ST_START;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT_END;
                timer_nxt = '0;
            end
            ST_WAIT_END: begin
                if (end_rise) begin
                    state_nxt = ST_SETTLE;
                    timer_nxt = '0;
                end else if (timer == TO_LAST) begin
                    tmo_set   = 1'b1;
                    state_nxt = ST_RETRY;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            ST_SETTLE: begin
                if (timer == SETTLE_LAST) begin
                    state_nxt = ST_CHECK;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            ST_CHECK: begin
                if (ld_s) begin
                    state_nxt = ST_LOCKED;
                    retry_nxt = '0;
                    timer_nxt = '0;
                end else begin
                    state_nxt = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (retry_cnt < RETRY_LIM) begin
                    retry_nxt = retry_cnt + 3'd1;
                    state_nxt = ST_START;
                end else begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_LOCKED: begin
                // Timer doubles as the consecutive-low filter while locked.
                if (ld_s) begin
                    timer_nxt = '0;
                end else if (timer == LOL_LAST) begin
                    lol_evt   = 1'b1;
                    retry_nxt = '0;
                    state_nxt = ST_START;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
                if (commit || pend_commit) begin
                    state_nxt = ST_START;
                    retry_nxt = '0;
                    pend_nxt  = 1'b0;
                end
            end
            ST_IDLE, ST_FAIL: begin
                if (commit || pend_commit) begin
                    state_nxt = ST_START;
                    retry_nxt = '0;
                    pend_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_PU_WAIT;
                timer_nxt = '0;
            end
        endcase
    end

    always_comb begin
        lol_cnt_nxt = clr ? 8'd0 : lol_cnt;
        if (lol_evt && (lol_cnt_nxt != 8'hFF)) begin
            lol_cnt_nxt = lol_cnt_nxt + 8'd1;
        end
    end

    // Stage p1: state, counters and registered status/strobe outputs
    always_ff @(posedge spi_clk or negedge sys_rest_n) begin
        if (!sys_rest_n) begin
            state             <= ST_PU_WAIT;
            timer             <= '0;
            retry_cnt         <= '0;
            pend_commit       <= 1'b0;
            seq_busy          <= 1'b0;
            seq_locked        <= 1'b0;
            seq_fail          <= 1'b0;
            adf4351_spi_start <= 1'b0;
            spi_timeout       <= 1'b0;
            lol_flag          <= 1'b0;
            wr_drop           <= 1'b0;
            lol_cnt           <= '0;
            adf_data_valid    <= 1'b0;
            adf_in_data       <= '0;
            adf_cfg_rddr      <= '0;
        end else begin
            state             <= state_nxt;
            timer             <= timer_nxt;
            retry_cnt         <= retry_nxt;
            pend_commit       <= pend_nxt;
            seq_busy          <= !is_rest(state_nxt);
            seq_locked        <= (state_nxt == ST_LOCKED);
            seq_fail          <= (state_nxt == ST_FAIL);
            adf4351_spi_start <= (state_nxt == ST_START);
            spi_timeout       <= tmo_set | (spi_timeout & ~clr);
            lol_flag          <= lol_evt | (lol_flag & ~clr);
            wr_drop           <= (wr_reg & busy) | (wr_drop & ~clr);
            lol_cnt           <= lol_cnt_nxt;
            adf_data_valid    <= wr_fwd;
            if (wr_fwd) begin
                adf_in_data  <= dsp_wr_data;
                adf_cfg_rddr <= dsp_wr_addr;
            end
        end
    end

endmodule

// File: tb/tb_adf4351_seq.sv
// Bench for adf4351_seq: a main instance with an SPI end-of-burst responder and a
// second instance whose config stage never answers, exercising the timeout path.
module tb_adf4351_seq;

    logic        spi_clk;
    logic        sys_rest_n;
    logic        dsp_wr_valid;
    logic [7:0]  dsp_wr_addr;
    logic [31:0] dsp_wr_data;
    logic [31:0] adf_in_data;
    logic [7:0]  adf_cfg_rddr;
    logic        adf_data_valid, adf_wr_en, adf4351_spi_start;
    logic        spi_all_end = 1'b0;
    logic        adf_ld;
    logic        seq_busy, seq_locked, seq_fail, spi_timeout, lol_flag, wr_drop;
    logic [2:0]  retry_cnt;
    logic [7:0]  lol_cnt;

    logic [31:0] to_in_data;
    logic [7:0]  to_cfg_rddr;
    logic        to_data_valid, to_wr_en, to_start;
    logic        to_busy, to_locked, to_fail, to_timeout, to_lol_flag, to_wr_drop;
    logic [2:0]  to_retry;
    logic [7:0]  to_lol_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 1;
    int start_cnt = 0;
    int last_start_cyc = 0;
    int to_start_cnt = 0;
    int to_start2_cyc = 0;
    int to_tmo_cyc = 0;
    int end_cd = 0;
    int resp_dly = 100;
    bit resp_en = 1'b1;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t sb_exp;

    adf4351_seq #(
        .POWERUP_DLY(20), .SPI_TO(512), .SETTLE(50), .LOL_FILT(16), .MAX_RETRY(3)
    ) u_dut (
        .spi_clk(spi_clk), .sys_rest_n(sys_rest_n),
        .dsp_wr_valid(dsp_wr_valid), .dsp_wr_addr(dsp_wr_addr), .dsp_wr_data(dsp_wr_data),
        .adf_in_data(adf_in_data), .adf_cfg_rddr(adf_cfg_rddr), .adf_data_valid(adf_data_valid),
        .adf_wr_en(adf_wr_en), .adf4351_spi_start(adf4351_spi_start),
        .spi_all_end(spi_all_end), .adf_ld(adf_ld),
        .seq_busy(seq_busy), .seq_locked(seq_locked), .seq_fail(seq_fail),
        .spi_timeout(spi_timeout), .lol_flag(lol_flag), .wr_drop(wr_drop),
        .retry_cnt(retry_cnt), .lol_cnt(lol_cnt)
    );

    adf4351_seq #(
        .POWERUP_DLY(20), .SPI_TO(64), .SETTLE(50), .LOL_FILT(16), .MAX_RETRY(3)
    ) u_to (
        .spi_clk(spi_clk), .sys_rest_n(sys_rest_n),
        .dsp_wr_valid(1'b0), .dsp_wr_addr(8'h00), .dsp_wr_data(32'h0),
        .adf_in_data(to_in_data), .adf_cfg_rddr(to_cfg_rddr), .adf_data_valid(to_data_valid),
        .adf_wr_en(to_wr_en), .adf4351_spi_start(to_start),
        .spi_all_end(1'b0), .adf_ld(1'b1),
        .seq_busy(to_busy), .seq_locked(to_locked), .seq_fail(to_fail),
        .spi_timeout(to_timeout), .lol_flag(to_lol_flag), .wr_drop(to_wr_drop),
        .retry_cnt(to_retry), .lol_cnt(to_lol_cnt)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    // Cycle 1 is the clock period in which reset is released.
    always @(posedge spi_clk) cyc <= sys_rest_n ? cyc + 1 : 1;

    // Config-stage model: raise spi_all_end for one cycle resp_dly cycles after start.
    always @(negedge spi_clk) begin
        spi_all_end = 1'b0;
        if (!sys_rest_n) begin
            end_cd = 0;
        end else begin
            if (end_cd > 0) begin
                end_cd--;
                if (end_cd == 0) spi_all_end = 1'b1;
            end
            if (adf4351_spi_start && resp_en) end_cd = resp_dly;
        end
    end

    always @(negedge spi_clk) begin
        if (sys_rest_n) begin
            if (adf4351_spi_start) begin
                start_cnt++;
                last_start_cyc = cyc;
            end
            if (to_start) begin
                to_start_cnt++;
                if (to_start_cnt == 2) to_start2_cyc = cyc;
            end
            if (to_timeout && to_tmo_cyc == 0) to_tmo_cyc = cyc;
        end
    end

    // Scoreboard: every forwarded write must match the oldest expected entry.
    always @(negedge spi_clk) begin
        if (sys_rest_n && adf_data_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_fwd: unexpected valid addr=%h data=%h, required no valid",
                         adf_cfg_rddr, adf_in_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({adf_cfg_rddr, adf_in_data} !== {sb_exp.a, sb_exp.d}) begin
                    n_bad++;
                    $display("FAIL wr_fwd: got addr=%h data=%h, required addr=%h data=%h",
                             adf_cfg_rddr, adf_in_data, sb_exp.a, sb_exp.d);
                end
            end
        end
    end

    task automatic drive_wr(input logic [7:0] a, input logic [31:0] d, input bit fwd);
        dsp_wr_valid = 1'b1;
        dsp_wr_addr  = a;
        dsp_wr_data  = d;
        if (fwd) exp_q.push_back('{a: a, d: d});
        @(negedge spi_clk);
        dsp_wr_valid = 1'b0;
        dsp_wr_addr  = 8'h00;
        dsp_wr_data  = 32'h0;
    endtask

    task automatic wait_locked(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge spi_clk);
            if (seq_locked) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rest_n   = 1'b0;
        dsp_wr_valid = 1'b0;
        dsp_wr_addr  = 8'h00;
        dsp_wr_data  = 32'h0;
        adf_ld       = 1'b1;
        repeat (3) @(negedge spi_clk);
        n_cmp++;
        if ({seq_busy, seq_locked, seq_fail, adf4351_spi_start, adf_data_valid, adf_wr_en} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b, required 000000",
                     {seq_busy, seq_locked, seq_fail, adf4351_spi_start, adf_data_valid, adf_wr_en});
        end
        n_cmp++;
        if ({spi_timeout, lol_flag, wr_drop, retry_cnt, lol_cnt, adf_cfg_rddr, adf_in_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_stat: got to=%b lol=%b drop=%b retry=%0d lolcnt=%0d addr=%h data=%h, required all 0",
                     spi_timeout, lol_flag, wr_drop, retry_cnt, lol_cnt, adf_cfg_rddr, adf_in_data);
        end
        sys_rest_n = 1'b1;
    endtask

    task automatic test_powerup_lock();
        int lock_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge spi_clk);
            if (seq_locked) begin
                lock_cyc = cyc;
                break;
            end
        end
        n_cmp++;
        if (start_cnt !== 1) begin
            n_bad++;
            $display("FAIL pu_start_count: got %0d, required 1", start_cnt);
        end
        n_cmp++;
        if (last_start_cyc !== 21) begin
            n_bad++;
            $display("FAIL pu_start_cycle: got %0d, required 21", last_start_cyc);
        end
        n_cmp++;
        if (lock_cyc < 170 || lock_cyc > 176) begin
            n_bad++;
            $display("FAIL pu_lock_cycle: got %0d, required 173+-3", lock_cyc);
        end
        n_cmp++;
        if ({retry_cnt, spi_timeout, seq_busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL pu_status: got retry=%0d to=%b busy=%b, required 0 0 0",
                     retry_cnt, spi_timeout, seq_busy);
        end
    endtask

    task automatic test_timeout();
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge spi_clk);
            if (to_fail) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (to_tmo_cyc !== 86) begin
            n_bad++;
            $display("FAIL to_timeout_cycle: got %0d, required 86", to_tmo_cyc);
        end
        n_cmp++;
        if (to_start2_cyc !== 87) begin
            n_bad++;
            $display("FAIL to_retry_start_cycle: got %0d, required 87", to_start2_cyc);
        end
        n_cmp++;
        if (!ok || to_start_cnt !== 4 || to_retry !== 3'd3 || to_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL to_fail: got fail=%b starts=%0d retry=%0d to=%b, required 1 4 3 1",
                     ok, to_start_cnt, to_retry, to_timeout);
        end
    endtask

    task automatic test_write_locked();
        drive_wr(8'hA3, 32'h0000_04B3, 1'b1);
        n_cmp++;
        if ({adf_data_valid, adf_cfg_rddr, adf_in_data} !== {1'b1, 8'hA3, 32'h0000_04B3}) begin
            n_bad++;
            $display("FAIL wr_a3: got v=%b addr=%h data=%h, required 1 a3 000004b3",
                     adf_data_valid, adf_cfg_rddr, adf_in_data);
        end
        @(negedge spi_clk);
        n_cmp++;
        if (adf_data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL wr_pulse_width: got valid=%b, required 0", adf_data_valid);
        end
        drive_wr(8'hA0, 32'h1111_2222, 1'b1);
        drive_wr(8'hA5, 32'hDEAD_BEEF, 1'b1);
        drive_wr(8'hA7, 32'h5555_5555, 1'b0);
        drive_wr(8'hA6, 32'h0000_0000, 1'b0);
        @(negedge spi_clk);
        n_cmp++;
        if ({adf_data_valid, wr_drop, seq_locked} !== 3'b001) begin
            n_bad++;
            $display("FAIL wr_ignored: got valid=%b drop=%b locked=%b, required 0 0 1",
                     adf_data_valid, wr_drop, seq_locked);
        end
    endtask

    task automatic test_write_dropped();
        bit ok;
        drive_wr(8'hA6, 32'h1, 1'b0);
        @(negedge spi_clk);
        drive_wr(8'hA3, 32'h0000_04B3, 1'b0);
        n_cmp++;
        if ({adf_data_valid, wr_drop, seq_busy} !== 3'b011) begin
            n_bad++;
            $display("FAIL wr_drop: got valid=%b drop=%b busy=%b, required 0 1 1",
                     adf_data_valid, wr_drop, seq_busy);
        end
        wait_locked(400, ok);
        drive_wr(8'hA6, 32'h2, 1'b0);
        n_cmp++;
        if ({ok, wr_drop, seq_locked} !== 3'b101) begin
            n_bad++;
            $display("FAIL wr_drop_clear: got relock=%b drop=%b locked=%b, required 1 0 1",
                     ok, wr_drop, seq_locked);
        end
    endtask

    task automatic test_lol();
        int base;
        bit ok;
        base = start_cnt;
        adf_ld = 1'b0;
        repeat (15) @(negedge spi_clk);
        adf_ld = 1'b1;
        repeat (10) @(negedge spi_clk);
        n_cmp++;
        if ({start_cnt - base, lol_flag, seq_locked} !== {32'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL lol_15_low: got starts=%0d flag=%b locked=%b, required 0 0 1",
                     start_cnt - base, lol_flag, seq_locked);
        end
        adf_ld = 1'b0;
        repeat (16) @(negedge spi_clk);
        adf_ld = 1'b1;
        repeat (5) @(negedge spi_clk);
        n_cmp++;
        if ({start_cnt - base, lol_flag, lol_cnt} !== {32'd1, 1'b1, 8'd1}) begin
            n_bad++;
            $display("FAIL lol_16_low: got starts=%0d flag=%b cnt=%0d, required 1 1 1",
                     start_cnt - base, lol_flag, lol_cnt);
        end
        wait_locked(400, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL lol_relock: got locked=%b, required 1", ok);
        end
    endtask

    task automatic test_fail_recover();
        int base;
        bit ok = 1'b0;
        base = start_cnt;
        adf_ld = 1'b0;
        drive_wr(8'hA6, 32'h1, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            @(negedge spi_clk);
            if (seq_fail) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if ({ok, seq_locked, retry_cnt} !== {1'b1, 1'b0, 3'd3} || start_cnt - base !== 4) begin
            n_bad++;
            $display("FAIL fail_state: got fail=%b locked=%b retry=%0d starts=%0d, required 1 0 3 4",
                     ok, seq_locked, retry_cnt, start_cnt - base);
        end
        adf_ld = 1'b1;
        repeat (3) @(negedge spi_clk);
        base = start_cnt;
        drive_wr(8'hA6, 32'h1, 1'b0);
        wait_locked(400, ok);
        n_cmp++;
        if ({ok, seq_fail, retry_cnt} !== {1'b1, 1'b0, 3'd0} || start_cnt - base !== 1) begin
            n_bad++;
            $display("FAIL fail_recover: got locked=%b fail=%b retry=%0d starts=%0d, required 1 0 0 1",
                     ok, seq_fail, retry_cnt, start_cnt - base);
        end
    endtask

    task automatic test_pend_commit();
        int base;
        bit ok;
        base = start_cnt;
        drive_wr(8'hA6, 32'h1, 1'b0);
        repeat (110) @(negedge spi_clk);
        drive_wr(8'hA6, 32'h1, 1'b0);
        adf_ld = 1'b0;
        repeat (5) @(negedge spi_clk);
        adf_ld = 1'b1;
        wait_locked(300, ok);
        repeat (300) @(negedge spi_clk);
        n_cmp++;
        if ({ok, seq_locked, retry_cnt} !== {1'b1, 1'b1, 3'd0} || start_cnt - base !== 2) begin
            n_bad++;
            $display("FAIL pend_commit: got first_lock=%b locked=%b retry=%0d starts=%0d, required 1 1 0 2",
                     ok, seq_locked, retry_cnt, start_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_start = 1'b0;
        drive_wr(8'hA6, 32'h1, 1'b0);
        repeat (5) @(negedge spi_clk);
        n_cmp++;
        if ({seq_busy, to_fail} !== 2'b11) begin
            n_bad++;
            $display("FAIL mid_pre: got busy=%b to_fail=%b, required 1 1", seq_busy, to_fail);
        end
        sys_rest_n = 1'b0;
        #1;
        n_cmp++;
        if ({adf_in_data, adf_cfg_rddr, adf_data_valid, adf_wr_en, adf4351_spi_start, seq_busy,
             seq_locked, seq_fail, spi_timeout, lol_flag, wr_drop, retry_cnt, lol_cnt} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got data=%h addr=%h busy=%b lolcnt=%0d retry=%0d, required all 0",
                     adf_in_data, adf_cfg_rddr, seq_busy, lol_cnt, retry_cnt);
        end
        n_cmp++;
        if ({to_fail, to_timeout, to_retry, to_busy} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_to: got fail=%b to=%b retry=%0d busy=%b, required all 0",
                     to_fail, to_timeout, to_retry, to_busy);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge spi_clk);
            if (adf4351_spi_start || to_start) saw_start = 1'b1;
        end
        n_cmp++;
        if (saw_start !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_no_start: got start during reset=%b, required 0", saw_start);
        end
        sys_rest_n = 1'b1;
        repeat (3) @(negedge spi_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_powerup_lock();
        test_timeout();
        test_write_locked();
        test_write_dropped();
        test_lol();
        test_fail_recover();
        test_pend_commit();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adf4351_seq.md
Name: adf4351_seq

Overview:
- Control sequencer directly upstream of the ADF4351 SPI configuration stage.
- Forwards DSP register writes (addresses A0–A5) to the config stage and launches the six-register SPI program burst.
- After each burst, waits for PLL settling, qualifies lock detect, and retries on failure.
- In steady state, supervises loss of lock and reports status to the DSP.

Parameters:
- POWERUP_DLY, 1000, cycles from reset release to the automatic first programming.
- SPI_TO, 4096, cycles allowed from start pulse to spi_all_end before a timeout is declared.
- SETTLE, 2000, cycles of PLL settling after spi_all_end before lock is checked.
- LOL_FILT, 16, consecutive cycles of lock detect low that count as loss of lock.
- MAX_RETRY, 3, reprogram attempts after the initial attempt before FAIL.

Ports:
- spi_clk  in  1  sole clock for the block.
- sys_rest_n  in  1  asynchronous active-low reset.
- dsp_wr_valid  in  1  one-cycle DSP write strobe.
- dsp_wr_addr  in  8  DSP write address.
- dsp_wr_data  in  32  DSP write data.
- adf_in_data  out  32  register data to the config stage.
- adf_cfg_rddr  out  8  register address to the config stage.
- adf_data_valid  out  1  one-cycle write strobe to the config stage.
- adf_wr_en  out  1  transfer type to the config stage; 0 = write burst; held 0 by this block.
- adf4351_spi_start  out  1  one-cycle start pulse to the config stage.
- spi_all_end  in  1  config stage end-of-burst; rising edge detected internally.
- adf_ld  in  1  asynchronous PLL lock detect pin.
- seq_busy  out  1  high while in any state other than IDLE, LOCKED or FAIL.
- seq_locked  out  1  high only in LOCKED.
- seq_fail  out  1  high only in FAIL.
- spi_timeout  out  1  sticky; set on SPI timeout.
- lol_flag  out  1  sticky; set on loss of lock.
- wr_drop  out  1  sticky; set when a write is dropped.
- retry_cnt  out  3  attempts used in the current sequence.
- lol_cnt  out  8  loss-of-lock events; saturates at 255.

Behaviour:
- Reset values: all outputs 0. State enters PU_WAIT.
- Async reset mid-sequence aborts immediately; no start pulse is emitted during reset.
- adf_ld passes through a 2-FF synchronizer; ld_s is the synchronized value.
- spi_all_end edge detect uses one register; a level held high counts once.

DSP decode, evaluated when dsp_wr_valid=1:
- Addr A0–A5, not busy: adf_in_data/adf_cfg_rddr/adf_data_valid registered, one cycle latency, valid pulse 1 cycle.
- Addr A0–A5, seq_busy=1: write dropped, wr_drop set.
- Addr A6 with data[0]=1: commit. From IDLE, LOCKED or FAIL, go to START next cycle. While busy, set pend_commit.
- Addr A6 with data[1]=1: clear spi_timeout, lol_flag, wr_drop and lol_cnt.
- Addr A6 with data[0] and data[1] both 1 in the same write: both actions occur.
- Any other address: ignored.

States:
- PU_WAIT: count POWERUP_DLY cycles, then START.
- START: adf4351_spi_start=1 for exactly one cycle; go to WAIT_END; timer cleared.
- WAIT_END:
  - spi_all_end rise: go to SETTLE.
  - Timer reaches SPI_TO-1: set spi_timeout, go to RETRY.
- SETTLE: count SETTLE cycles, then CHECK.
- CHECK (1 cycle):
  - ld_s=1: go to LOCKED and clear retry_cnt.
  - ld_s=0: go to RETRY.
- RETRY:
  - retry_cnt < MAX_RETRY: retry_cnt+1, go to START.
  - Otherwise: go to FAIL.
- LOCKED: consecutive-low counter on ld_s, cleared by ld_s=1.
  - Counter reaches LOL_FILT: set lol_flag, lol_cnt+1 (saturating), retry_cnt cleared, go to START.
  - ld_s low for LOL_FILT-1 cycles then high: no event.
- FAIL: hold until commit; commit clears retry_cnt and goes to START.
- IDLE: reached only when a commit is pending-cleared with nothing to do. A busy-time pend_commit is consumed on entry to LOCKED or FAIL, going to START next cycle with retry_cnt cleared.
- A commit arriving in the same cycle as a LOCKED loss-of-lock event yields a single START.
- An ld_s glitch during SETTLE is ignored; only the CHECK sample matters.
- Counters are 16-bit; parameter values must fit in 16 bits.

Test Plan:
- Reset release with POWERUP_DLY=20, SETTLE=50, ld tied 1; spi_all_end returned 100 cycles after start -> exactly one start pulse at cycle 21; seq_locked=1 at 173±3 cycles; retry_cnt=0.
- DSP write A3=0x000004B3 while LOCKED -> adf_cfg_rddr=A3, adf_in_data=0x000004B3, one-cycle adf_data_valid one cycle later. Same write during WAIT_END -> no valid pulse; wr_drop=1.
- ld tied 0, MAX_RETRY=3 -> exactly 4 start pulses; seq_fail=1; retry_cnt=3. Then A6 data 0x1 with ld=1 -> reaches LOCKED.
- spi_all_end never asserted, SPI_TO=64 -> spi_timeout=1 after 64 cycles; retry sequence proceeds.
- In LOCKED, ld low 15 cycles then high -> no event. ld low 16 cycles -> lol_flag=1, lol_cnt=1, new start pulse.
- A6 data 0x1 during SETTLE -> after LOCKED, exactly one extra start pulse. Reset asserted mid WAIT_END -> all outputs 0 immediately.
